// File: rtl/exc_commit_ctrl_pkg.sv
// Exception codes, exc_flags bit layout and priority table for the W-stage commit controller.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // exc_flags bit indices; a lower index wins when several flags are set
    localparam int unsigned F_RI     = 0;
    localparam int unsigned F_OV     = 1;
    localparam int unsigned F_SYS    = 2;
    localparam int unsigned F_BP     = 3;
    localparam int unsigned F_ADEL   = 4;
    localparam int unsigned F_ADES   = 5;
    localparam int unsigned F_TLBL   = 6;
    localparam int unsigned F_TLBS   = 7;
    localparam int unsigned F_MOD    = 8;
    localparam int unsigned F_REFILL = 9;

    typedef enum logic {IDLE, COMMIT} state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
        logic        badv_en;
        logic        eret;
        logic        refill;
    } exc_rec_t;

    function automatic logic [4:0] flag_code(input int unsigned idx);
        case (idx)
            F_RI:     return EXC_RI;
            F_OV:     return EXC_OV;
            F_SYS:    return EXC_SYS;
            F_BP:     return EXC_BP;
            F_ADEL:   return EXC_ADEL;
            F_ADES:   return EXC_ADES;
            F_TLBL:   return EXC_TLBL;
            F_TLBS:   return EXC_TLBS;
            F_MOD:    return EXC_MOD;
            F_REFILL: return EXC_TLBL;
            default:  return EXC_RI;
        endcase
    endfunction

    // Address-class exceptions report the faulting address in BadVAddr
    function automatic logic flag_has_badv(input int unsigned idx);
        return (idx >= F_ADEL) && (idx <= F_REFILL);
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_int_sync.sv
// Per-bit flop-chain synchroniser for asynchronous interrupt lines; STAGES=0 is a wire.
module int_sync #(
    parameter int unsigned W      = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [W-1:0] chain [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
                end else begin
                    chain[0] <= d;
                    for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/exc_commit_ctrl.sv
// W-stage precise exception / interrupt / ERET commit controller with a one-cycle
// registered CP0 update record, pipeline flush and PC redirect.
module exc_commit_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned NUM_HW_INT    = 6,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned N_EXC         = 10,
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic [31:0]           pc,
    input  logic                  is_ds,
    input  logic [N_EXC-1:0]      exc_flags,
    input  logic [31:0]           bad_addr,
    input  logic                  is_eret,
    input  logic [31:0]           epc_in,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [1:0]            sw_int,
    input  logic [NUM_HW_INT+1:0] status_im,
    input  logic                  status_ie,
    input  logic                  status_exl,
    output logic [NUM_HW_INT+1:0] cause_ip,
    output logic                  cp0_we,
    output logic [4:0]            cp0_exc_code,
    output logic [31:0]           cp0_epc,
    output logic                  cp0_bd,
    output logic                  badv_we,
    output logic [31:0]           cp0_badvaddr,
    output logic                  exl_set,
    output logic                  exl_clr,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc
);

    logic [NUM_HW_INT-1:0] hw_sync;
    state_t                state;
    logic                  commit_ok;
    logic                  int_req;
    logic                  detect;
    exc_rec_t              rec;

    int_sync #(.W(NUM_HW_INT), .STAGES(SYNC_STAGES)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hw_sync)
    );

    assign cause_ip = {hw_sync, sw_int};

    always_comb begin
        commit_ok = inst_valid & !(stall_w & !flush_w) & !flush_w & (state == IDLE);
        int_req   = status_ie & !status_exl & (|(cause_ip & status_im));
        detect    = 1'b0;
        rec       = '0;
        // With EXL already set, EPC is rewritten with its current value so it is preserved
        rec.epc   = status_exl ? epc_in : (is_ds ? pc - 32'd4 : pc);
        rec.bd    = is_ds;
        if (int_req) begin
            detect   = 1'b1;
            rec.code = EXC_INT;
        end else if (pc[1:0] != 2'b00) begin
            detect      = 1'b1;
            rec.code    = EXC_ADEL;
            rec.badv    = pc;
            rec.badv_en = 1'b1;
        end else if (is_eret && (epc_in[1:0] != 2'b00)) begin
            detect      = 1'b1;
            rec.code    = EXC_ADEL;
            rec.badv    = epc_in;
            rec.badv_en = 1'b1;
        end else begin
            for (int unsigned i = 0; i < N_EXC; i++) begin
                if (!detect && exc_flags[i]) begin
                    detect      = 1'b1;
                    rec.code    = flag_code(i);
                    rec.badv_en = flag_has_badv(i);
                    rec.badv    = flag_has_badv(i) ? bad_addr : '0;
                    rec.refill  = (i == F_REFILL);
                end
            end
        end
        rec.eret = is_eret & !detect;
    end

    // The output registers are the commit record: loaded on IDLE->COMMIT, cleared otherwise
    always_ff @(posedge clk) begin
        cp0_we         <= 1'b0;
        cp0_exc_code   <= '0;
        cp0_epc        <= '0;
        cp0_bd         <= 1'b0;
        badv_we        <= 1'b0;
        cp0_badvaddr   <= '0;
        exl_set        <= 1'b0;
        exl_clr        <= 1'b0;
        redirect_valid <= 1'b0;
        redirect_pc    <= '0;
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_ok && (detect || is_eret)) begin
                        state          <= COMMIT;
                        cp0_we         <= !rec.eret;
                        exl_set        <= !rec.eret;
                        exl_clr        <= rec.eret;
                        cp0_exc_code   <= rec.eret ? '0 : rec.code;
                        cp0_epc        <= rec.eret ? '0 : rec.epc;
                        cp0_bd         <= !rec.eret & rec.bd;
                        badv_we        <= rec.badv_en;
                        cp0_badvaddr   <= rec.badv;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= rec.eret ? epc_in :
                                          (rec.refill && !status_exl) ? REFILL_VECTOR : EXC_VECTOR;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed scoreboard bench for exc_commit_ctrl: expected commit records are queued at drive
// time and compared against the one-cycle CP0/redirect pulse.
module tb_exc_commit_ctrl;
    import exc_pkg::*;

    localparam logic [31:0] EXC_VEC    = 32'hBFC0_0380;
    localparam logic [31:0] REFILL_VEC = 32'hBFC0_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, stall_w, flush_w, is_ds, is_eret;
    logic [31:0] pc, bad_addr, epc_in;
    logic [9:0]  exc_flags;
    logic [5:0]  hw_int;
    logic [1:0]  sw_int;
    logic [7:0]  status_im;
    logic        status_ie, status_exl;
    logic [7:0]  cause_ip;
    logic        cp0_we, cp0_bd, badv_we, exl_set, exl_clr, redirect_valid;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;

    int unsigned total  = 0;
    int unsigned passed = 0;

    typedef struct {
        logic        we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bwe;
        logic [31:0] badv;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    exc_commit_ctrl #(
        .NUM_HW_INT    (6),
        .SYNC_STAGES   (2),
        .N_EXC         (10),
        .EXC_VECTOR    (EXC_VEC),
        .REFILL_VECTOR (REFILL_VEC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .stall_w        (stall_w),
        .flush_w        (flush_w),
        .pc             (pc),
        .is_ds          (is_ds),
        .exc_flags      (exc_flags),
        .bad_addr       (bad_addr),
        .is_eret        (is_eret),
        .epc_in         (epc_in),
        .hw_int         (hw_int),
        .sw_int         (sw_int),
        .status_im      (status_im),
        .status_ie      (status_ie),
        .status_exl     (status_exl),
        .cause_ip       (cause_ip),
        .cp0_we         (cp0_we),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_epc        (cp0_epc),
        .cp0_bd         (cp0_bd),
        .badv_we        (badv_we),
        .cp0_badvaddr   (cp0_badvaddr),
        .exl_set        (exl_set),
        .exl_clr        (exl_clr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic push_exc(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                            input logic bwe, input logic [31:0] badv, input logic [31:0] rpc);
        exp_t e;
        e.we = 1'b1; e.code = code; e.epc = epc; e.bd = bd;
        e.bwe = bwe; e.badv = badv; e.rpc = rpc;
        sb.push_back(e);
    endtask

    task automatic push_eret(input logic [31:0] rpc);
        exp_t e;
        e.we = 1'b0; e.code = '0; e.epc = '0; e.bd = 1'b0;
        e.bwe = 1'b0; e.badv = '0; e.rpc = rpc;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the commit pulse, compare it with the queued record, then check width
    task automatic await_commit(input string tag, input int unsigned budget,
                                input int unsigned want_lat);
        int unsigned lat = 0;
        exp_t        e;
        for (int unsigned i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (redirect_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        inst_valid = 1'b0;
        exc_flags  = '0;
        is_eret    = 1'b0;
        chk({tag, "_latency"}, lat, want_lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (lat != 0) begin
                chk({tag, "_cp0_we"},  cp0_we,      e.we);
                chk({tag, "_exl_set"}, exl_set,     e.we);
                chk({tag, "_exl_clr"}, exl_clr,     !e.we);
                chk({tag, "_badv_we"}, badv_we,     e.bwe);
                chk({tag, "_rpc"},     redirect_pc, e.rpc);
                if (e.we) begin
                    chk({tag, "_code"}, cp0_exc_code, e.code);
                    chk({tag, "_epc"},  cp0_epc,      e.epc);
                    chk({tag, "_bd"},   cp0_bd,       e.bd);
                end
                if (e.bwe) chk({tag, "_badv"}, cp0_badvaddr, e.badv);
            end
        end
        @(negedge clk);
        chk({tag, "_width"}, {redirect_valid, cp0_we, exl_set, exl_clr, badv_we}, 32'd0);
    endtask

    task automatic no_commit(input string tag, input int unsigned cycles);
        int unsigned hits = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (redirect_valid !== 1'b0 || cp0_we !== 1'b0 || exl_clr !== 1'b0) hits++;
        end
        chk(tag, hits, 32'd0);
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; stall_w = 1'b0; flush_w = 1'b0; is_ds = 1'b0;
        is_eret = 1'b0; pc = 32'h8000_0000; bad_addr = '0; epc_in = '0; exc_flags = '0;
        hw_int = '0; sw_int = '0; status_im = '0; status_ie = 1'b1; status_exl = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cause_ip", cause_ip, 32'd0);
        chk("rst_redirect", redirect_valid, 32'd0);
        chk("rst_cp0_we", cp0_we, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_exl", {exl_set, exl_clr, badv_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Overflow, not in a delay slot
        pc = 32'h8000_0104; exc_flags[F_OV] = 1'b1; inst_valid = 1'b1;
        push_exc(EXC_OV, 32'h8000_0104, 1'b0, 1'b0, '0, EXC_VEC);
        await_commit("ov", 4, 1);

        // Syscall in a delay slot: EPC points at the branch
        pc = 32'h8000_0200; is_ds = 1'b1; exc_flags[F_SYS] = 1'b1; inst_valid = 1'b1;
        push_exc(EXC_SYS, 32'h8000_01FC, 1'b1, 1'b0, '0, EXC_VEC);
        await_commit("ds_sys", 4, 1);
        is_ds = 1'b0;

        // Fetch misalignment outranks a simultaneous overflow
        pc = 32'h8000_0101; exc_flags[F_OV] = 1'b1; inst_valid = 1'b1; bad_addr = 32'h1234_5678;
        push_exc(EXC_ADEL, 32'h8000_0101, 1'b0, 1'b1, 32'h8000_0101, EXC_VEC);
        await_commit("fetch_adel", 4, 1);

        // Hardware interrupt through the two-stage synchroniser
        pc = 32'h8000_0300; status_im = 8'b0010_0000; hw_int = 6'b00_1000; inst_valid = 1'b1;
        push_exc(EXC_INT, 32'h8000_0300, 1'b0, 1'b0, '0, EXC_VEC);
        await_commit("int", 6, 3);
        chk("cause_ip_sync", cause_ip, 32'h20);
        hw_int = '0;
        repeat (3) @(negedge clk);

        // Same interrupt with IE clear is never taken
        status_ie = 1'b0; hw_int = 6'b00_1000; inst_valid = 1'b1;
        no_commit("int_masked", 6);
        inst_valid = 1'b0; hw_int = '0; status_ie = 1'b1;
        repeat (3) @(negedge clk);

        // Misaligned ERET becomes AdEL with BadVAddr = EPC
        pc = 32'h8000_0400; is_eret = 1'b1; epc_in = 32'h8000_0002; inst_valid = 1'b1;
        push_exc(EXC_ADEL, 32'h8000_0400, 1'b0, 1'b1, 32'h8000_0002, EXC_VEC);
        await_commit("eret_bad", 4, 1);

        // Aligned ERET returns to EPC
        pc = 32'h8000_0404; is_eret = 1'b1; epc_in = 32'h8000_1000; inst_valid = 1'b1;
        push_eret(32'h8000_1000);
        await_commit("eret_ok", 4, 1);

        // Stalled W holds off the commit; RI beats Ov once released
        pc = 32'h8000_0500; stall_w = 1'b1; exc_flags[F_RI] = 1'b1; exc_flags[F_OV] = 1'b1;
        inst_valid = 1'b1;
        no_commit("stall_hold", 3);
        push_exc(EXC_RI, 32'h8000_0500, 1'b0, 1'b0, '0, EXC_VEC);
        stall_w = 1'b0;
        await_commit("stall_ri", 2, 1);

        // Reset asserted during the commit pulse
        pc = 32'h8000_0600; exc_flags[F_OV] = 1'b1; inst_valid = 1'b1;
        @(negedge clk);
        chk("rstc_pulse", redirect_valid, 32'd1);
        rst = 1'b1; inst_valid = 1'b0; exc_flags = '0;
        @(negedge clk);
        chk("rstc_strobes", {redirect_valid, cp0_we, exl_set, exl_clr, badv_we}, 32'd0);
        chk("rstc_rpc", redirect_pc, 32'd0);
        chk("rstc_epc", cp0_epc, 32'd0);
        rst = 1'b0;
        no_commit("rstc_quiet", 2);

        // TLB refill with EXL clear goes to the refill vector
        pc = 32'h8000_0700; bad_addr = 32'h0040_1234; exc_flags[F_REFILL] = 1'b1; inst_valid = 1'b1;
        push_exc(EXC_TLBL, 32'h8000_0700, 1'b0, 1'b1, 32'h0040_1234, REFILL_VEC);
        await_commit("refill", 4, 1);

        // Same refill with EXL set: general vector, EPC left at its current value
        status_exl = 1'b1; epc_in = 32'h8000_1000;
        pc = 32'h8000_0704; exc_flags[F_REFILL] = 1'b1; inst_valid = 1'b1;
        push_exc(EXC_TLBL, 32'h8000_1000, 1'b0, 1'b1, 32'h0040_1234, EXC_VEC);
        await_commit("refill_exl", 4, 1);
        status_exl = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
